// File: rtl/uart_responder.sv
// uart_responder: host rdn/wrn strobe bus to 8N1 serial bridge.
// One-byte TX holding register, one-byte RX buffer, LSB first.
module uart_responder #(
    parameter int CLK_DIV = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rdn,
    input  logic       wrn,
    inout  wire  [7:0] ram1_data,
    input  logic       rxd,
    output logic       txd,
    output logic       data_ready,
    output logic       tbre,
    output logic       tsre
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] BIT_END = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] MID_END = CW'(CLK_DIV / 2 - 1);

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    // host strobe history
    logic wrn_q;
    logic rdn_q;

    // transmit side
    tx_state_e     tx_state_q;
    logic [7:0]    stage_q;
    logic [7:0]    hold_q;
    logic [7:0]    tx_shift_q;
    logic [CW-1:0] tx_cnt_q;
    logic [2:0]    tx_idx_q;
    logic          txd_q;
    logic          tbre_q;
    logic          tsre_q;

    // receive side
    rx_state_e     rx_state_q;
    logic          rx_s1_q;
    logic          rx_s2_q;
    logic          rx_prev_q;
    logic [7:0]    rx_shift_q;
    logic [CW-1:0] rx_cnt_q;
    logic [2:0]    rx_idx_q;
    logic          rx_wait_q;
    logic [7:0]    rx_buf_q;
    logic          ready_q;

    logic          wr_edge_d;
    logic          rd_edge_d;
    logic [CW-1:0] tx_cnt_d;
    logic [CW-1:0] rx_cnt_d;
    logic [2:0]    tx_idx_d;
    logic [2:0]    rx_idx_d;

    assign wr_edge_d = !wrn_q && wrn;
    assign rd_edge_d = !rdn_q && rdn;
    assign tx_cnt_d  = tx_cnt_q + CW'(1);
    assign rx_cnt_d  = rx_cnt_q + CW'(1);
    assign tx_idx_d  = tx_idx_q + 3'd1;
    assign rx_idx_d  = rx_idx_q + 3'd1;

    assign ram1_data  = rdn ? 8'hzz : rx_buf_q;
    assign txd        = txd_q;
    assign tbre       = tbre_q;
    assign tsre       = tsre_q;
    assign data_ready = ready_q;

    // host write capture plus transmit FSM; they share tbre
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrn_q      <= 1'b1;
            stage_q    <= 8'h00;
            hold_q     <= 8'h00;
            tx_shift_q <= 8'h00;
            tx_cnt_q   <= '0;
            tx_idx_q   <= 3'd0;
            txd_q      <= 1'b1;
            tbre_q     <= 1'b1;
            tsre_q     <= 1'b1;
            tx_state_q <= TX_IDLE;
        end else begin
            wrn_q <= wrn;
            if (!wrn) begin
                stage_q <= ram1_data;
            end
            // only taken while tbre=1, so never collides with a load
            if (wr_edge_d && tbre_q) begin
                hold_q <= stage_q;
                tbre_q <= 1'b0;
            end
            unique case (tx_state_q)
                TX_IDLE: begin
                    if (!tbre_q) begin
                        tx_shift_q <= hold_q;
                        tbre_q     <= 1'b1;
                        tsre_q     <= 1'b0;
                        txd_q      <= 1'b0;
                        tx_cnt_q   <= '0;
                        tx_state_q <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt_q == BIT_END) begin
                        tx_cnt_q   <= '0;
                        tx_idx_q   <= 3'd0;
                        txd_q      <= tx_shift_q[0];
                        tx_state_q <= TX_DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_d;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt_q == BIT_END) begin
                        tx_cnt_q <= '0;
                        if (tx_idx_q == 3'd7) begin
                            txd_q      <= 1'b1;
                            tx_state_q <= TX_STOP;
                        end else begin
                            tx_idx_q <= tx_idx_d;
                            txd_q    <= tx_shift_q[tx_idx_d];
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_d;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt_q == BIT_END) begin
                        tx_cnt_q <= '0;
                        if (!tbre_q) begin
                            // holding full: chain next frame, line stays busy
                            tx_shift_q <= hold_q;
                            tbre_q     <= 1'b1;
                            txd_q      <= 1'b0;
                            tx_state_q <= TX_START;
                        end else begin
                            tsre_q     <= 1'b1;
                            tx_state_q <= TX_IDLE;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_d;
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    // rxd synchronizer, receive FSM and host read handshake
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdn_q      <= 1'b1;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_shift_q <= 8'h00;
            rx_cnt_q   <= '0;
            rx_idx_q   <= 3'd0;
            rx_wait_q  <= 1'b0;
            rx_buf_q   <= 8'h00;
            ready_q    <= 1'b0;
            rx_state_q <= RX_IDLE;
        end else begin
            rdn_q     <= rdn;
            rx_s1_q   <= rxd;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            // a completing byte below overrides this clear
            if (rd_edge_d) begin
                ready_q <= 1'b0;
            end
            unique case (rx_state_q)
                RX_IDLE: begin
                    if (rx_prev_q && !rx_s2_q) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt_q == MID_END) begin
                        rx_cnt_q <= '0;
                        rx_idx_q <= 3'd0;
                        if (rx_s2_q) begin
                            rx_state_q <= RX_IDLE;
                        end else begin
                            rx_state_q <= RX_DATA;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_d;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == BIT_END) begin
                        rx_cnt_q   <= '0;
                        rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
                        rx_idx_q   <= rx_idx_d;
                        if (rx_idx_q == 3'd7) begin
                            rx_wait_q  <= 1'b0;
                            rx_state_q <= RX_STOP;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_d;
                    end
                end
                RX_STOP: begin
                    if (rx_wait_q) begin
                        if (rx_s2_q) begin
                            rx_wait_q  <= 1'b0;
                            rx_state_q <= RX_IDLE;
                        end
                    end else if (rx_cnt_q == BIT_END) begin
                        rx_cnt_q <= '0;
                        if (rx_s2_q) begin
                            rx_buf_q   <= rx_shift_q;
                            ready_q    <= 1'b1;
                            rx_state_q <= RX_IDLE;
                        end else begin
                            // framing error: drop byte, wait for idle line
                            rx_wait_q <= 1'b1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_d;
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_responder.sv
// tb_uart_responder: directed stimulus with queued expectations.
// Monitors decode txd frames, tsre busy runs and bus reads.
module tb_uart_responder;

    logic       clk;
    logic       rst;
    logic       rdn;
    logic       wrn;
    logic       rxd;
    logic       txd;
    logic       data_ready;
    logic       tbre;
    logic       tsre;
    wire  [7:0] ram1_data;
    logic       tb_en;
    logic [7:0] tb_val;
    logic       mon_en;

    int n_vec;
    int n_err;

    logic [7:0] tx_q[$];
    int         len_q[$];
    logic [7:0] rd_q[$];

    assign ram1_data = tb_en ? tb_val : 8'hzz;

    uart_responder #(
        .CLK_DIV(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rdn       (rdn),
        .wrn       (wrn),
        .ram1_data (ram1_data),
        .rxd       (rxd),
        .txd       (txd),
        .data_ready(data_ready),
        .tbre      (tbre),
        .tsre      (tsre)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic host_write(input logic [7:0] b);
        @(negedge clk);
        tb_val = b;
        tb_en  = 1'b1;
        wrn    = 1'b0;
        @(negedge clk);
        wrn   = 1'b1;
        tb_en = 1'b0;
    endtask

    task automatic host_read(input logic [7:0] exp);
        rd_q.push_back(exp);
        @(negedge clk);
        rdn = 1'b0;
        @(negedge clk);
        rdn = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stopb);
        logic [9:0] bits;
        bits = {stopb, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rxd = bits[i];
            repeat (3) @(negedge clk);
        end
        @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(tsre === 1'b1 && tbre === 1'b1) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("tx_idle_timeout", {31'd0, tsre}, 32'd1);
    endtask

    // txd frame decoder
    initial begin : tx_mon
        logic [7:0] got;
        logic [7:0] exp;
        logic       ok;
        forever begin
            @(posedge clk); #1;
            if (mon_en && txd === 1'b0) begin
                ok = 1'b1;
                repeat (2) begin @(posedge clk); #1; end
                if (txd !== 1'b0) ok = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    repeat (4) begin @(posedge clk); #1; end
                    got[i] = txd;
                end
                repeat (4) begin @(posedge clk); #1; end
                if (txd !== 1'b1) ok = 1'b0;
                @(posedge clk); #1;
                if (tx_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL tx_unexpected: got frame %0h", got);
                end else begin
                    exp = tx_q.pop_front();
                    check("tx_frame", {23'd0, ok, got}, {23'd0, 1'b1, exp});
                end
            end
        end
    end

    // tsre low-run length
    initial begin : tsre_mon
        int   n;
        int   exp;
        logic en;
        forever begin
            @(posedge clk); #1;
            if (tsre === 1'b0) begin
                en = mon_en;
                n  = 1;
                while (n < 1000) begin
                    @(posedge clk); #1;
                    if (tsre !== 1'b0) break;
                    n++;
                end
                if (en) begin
                    if (len_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL tsre_unexpected: got run %0d", n);
                    end else begin
                        exp = len_q.pop_front();
                        check("tsre_run", n, exp);
                    end
                end
            end
        end
    end

    // bus value on each rdn falling edge
    initial begin : rd_mon
        logic prev;
        prev = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (rdn === 1'b0 && prev === 1'b1) begin
                if (rd_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL rd_unexpected: got %0h", ram1_data);
                end else begin
                    check("rd_bus", {24'd0, ram1_data}, {24'd0, rd_q.pop_front()});
                end
            end
            prev = rdn;
        end
    end

    initial begin : stim
        n_vec  = 0;
        n_err  = 0;
        rst    = 1'b0;
        rdn    = 1'b1;
        wrn    = 1'b1;
        rxd    = 1'b1;
        tb_en  = 1'b0;
        tb_val = 8'h00;
        mon_en = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_txd", {31'd0, txd}, 32'd1);
        check("rst_tbre", {31'd0, tbre}, 32'd1);
        check("rst_tsre", {31'd0, tsre}, 32'd1);
        check("rst_ready", {31'd0, data_ready}, 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // single frame 0xA5
        tx_q.push_back(8'hA5);
        len_q.push_back(40);
        host_write(8'hA5);
        @(negedge clk);
        check("a5_tbre_low", {31'd0, tbre}, 32'd0);
        @(negedge clk);
        check("a5_tbre_back", {31'd0, tbre}, 32'd1);
        check("a5_tsre_busy", {31'd0, tsre}, 32'd0);
        check("a5_start_bit", {31'd0, txd}, 32'd0);
        wait_idle();
        repeat (4) @(negedge clk);

        // back-to-back frames, third write dropped
        tx_q.push_back(8'h3C);
        tx_q.push_back(8'hC3);
        len_q.push_back(80);
        host_write(8'h3C);
        repeat (2) @(negedge clk);
        host_write(8'hC3);
        @(negedge clk);
        check("b2b_tbre_full", {31'd0, tbre}, 32'd0);
        host_write(8'hEE);
        @(negedge clk);
        check("b2b_drop_tbre", {31'd0, tbre}, 32'd0);
        wait_idle();
        repeat (10) @(negedge clk);

        // receive 0x5A
        send_rx(8'h5A, 1'b1);
        repeat (4) @(negedge clk);
        check("rx5a_ready", {31'd0, data_ready}, 32'd1);
        tb_en  = 1'b1;
        tb_val = 8'h00;
        #1;
        check("bus_released", {24'd0, ram1_data}, 32'd0);
        tb_en = 1'b0;
        host_read(8'h5A);
        check("rx5a_cleared", {31'd0, data_ready}, 32'd0);

        // overrun
        send_rx(8'h11, 1'b1);
        repeat (4) @(negedge clk);
        check("ovr_ready1", {31'd0, data_ready}, 32'd1);
        send_rx(8'h22, 1'b1);
        repeat (4) @(negedge clk);
        check("ovr_ready2", {31'd0, data_ready}, 32'd1);
        host_read(8'h22);
        check("ovr_cleared", {31'd0, data_ready}, 32'd0);

        // framing error keeps buffer
        send_rx(8'h77, 1'b0);
        repeat (6) @(negedge clk);
        check("frm_ready", {31'd0, data_ready}, 32'd0);
        host_read(8'h22);

        // one-cycle glitch
        @(negedge clk);
        rxd = 1'b0;
        @(negedge clk);
        rxd = 1'b1;
        repeat (50) @(negedge clk);
        check("glitch_ready", {31'd0, data_ready}, 32'd0);

        // reset mid-TX and mid-RX
        mon_en = 1'b0;
        host_write(8'h55);
        @(negedge clk);
        rxd = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_txd", {31'd0, txd}, 32'd1);
        check("abort_tbre", {31'd0, tbre}, 32'd1);
        check("abort_tsre", {31'd0, tsre}, 32'd1);
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_txd_idle", {31'd0, txd}, 32'd1);
        check("abort_no_rx", {31'd0, data_ready}, 32'd0);
        mon_en = 1'b1;
        host_read(8'h00);

        // recovery exchange 0x81
        tx_q.push_back(8'h81);
        len_q.push_back(40);
        host_write(8'h81);
        repeat (2) @(negedge clk);
        wait_idle();
        send_rx(8'h81, 1'b1);
        repeat (4) @(negedge clk);
        check("rx81_ready", {31'd0, data_ready}, 32'd1);
        host_read(8'h81);
        check("rx81_cleared", {31'd0, data_ready}, 32'd0);

        repeat (20) @(negedge clk);
        check("tx_q_drained", tx_q.size(), 32'd0);
        check("len_q_drained", len_q.size(), 32'd0);
        check("rd_q_drained", rd_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: sim time exceeded");
        $fatal(1);
    end

endmodule

// File: doc/uart_responder.md
# uart_responder

Synthesizable stand-in for the on-board CPLD UART, serving the host-side `rdn`/`wrn` strobe protocol with `data_ready`/`tbre`/`tsre` status over the shared 8-bit data bus. It serializes written bytes onto `txd` and deserializes `rxd` into a one-byte receive buffer, both 8N1, LSB first. It sits between the serial-port controller and the physical pins. It serves as the responder end of the serial interface, both in simulation benches and on boards without the CPLD.

## Interface
Parameters:
- CLK_DIV, default 16: clk cycles per serial bit; must be even and ≥4.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- rdn  in  1  read strobe, active-low; while low the block drives the bus with the receive buffer.
- wrn  in  1  write strobe, active-low; the bus is sampled while low.
- ram1_data  inout  8  shared data bus; driven only while rdn=0, otherwise high-Z.
- rxd  in  1  serial input, asynchronous, idle high.
- txd  out  1  serial output, idle high.
- data_ready  out  1  receive buffer holds an unread byte.
- tbre  out  1  transmit holding register empty.
- tsre  out  1  transmit shift register empty (line idle).

## Operation
- Host write:
  - Each clk with wrn=0, ram1_data is captured into a staging register.
  - When a wrn rising edge is detected (previous sample 0, current 1) and tbre=1, the staging value moves to the holding register and tbre←0.
  - A write edge while tbre=0 is ignored; holding register and tbre are unchanged.
- TX FSM states are TX_IDLE, TX_START, TX_DATA, TX_STOP:
  - TX_IDLE: if tbre=0, load shift register from holding, tbre←1, tsre←0, go to TX_START.
  - TX_START: txd=0 for CLK_DIV cycles.
  - TX_DATA: 8 bits, LSB first, CLK_DIV cycles each; a 3-bit index counts 0..7.
  - TX_STOP: txd=1 for CLK_DIV cycles. If the holding register is full, reload and go directly to TX_START, keeping tsre=0. Otherwise tsre←1 and go to TX_IDLE.
- RX input path: rxd passes through a 2-flop synchronizer before any logic.
- RX FSM states are RX_IDLE, RX_START, RX_DATA, RX_STOP:
  - RX_IDLE: a synchronized 1→0 edge goes to RX_START and resets the bit timer.
  - RX_START: at CLK_DIV/2 cycles, if the line is 1 this is a false start and the FSM returns to RX_IDLE; otherwise go to RX_DATA.
  - RX_DATA: sample each bit every CLK_DIV cycles from the start mid-point, LSB first.
  - RX_STOP: sample at mid-bit. If 1, the byte is written to the receive buffer and data_ready←1. If 0, it is a framing error: the byte is discarded and the buffer and data_ready are unchanged. In both cases the FSM then waits for line=1 before RX_IDLE.
- Overrun: a new byte completing while data_ready=1 overwrites the buffer; data_ready stays 1.
- Host read:
  - While rdn=0, ram1_data = receive buffer (combinational output enable).
  - A rdn rising edge clears data_ready.
  - If a rdn rising edge and an RX byte completion occur in the same cycle, the new byte is stored and data_ready stays 1.
- rdn=0 and wrn=0 simultaneously is a host protocol violation; the bus is still driven, and write capture samples the bus, which then holds the block's own driven value.

## Timing
- Reset values (asserted asynchronously):
  - Outputs: txd=1, tbre=1, tsre=1, data_ready=0.
  - Bus high-Z unless rdn=0.
  - Receive buffer 0x00, both FSMs idle.
- Reset mid-frame aborts immediately: txd returns to 1 and any partial RX byte is lost.
- Write edge → tbre=0 on the next clk edge.
- TX_IDLE load → tbre=1 and tsre=0 on the following edge; start bit appears on txd that same edge.
- Frame length is 10·CLK_DIV cycles.
- tsre=1 on the edge that ends the stop bit.
- RX latency: data_ready rises 2 (synchronizer) + 1 cycles after the stop-bit mid-sample.
- Host stalls on tbre and tsre, so it needs no knowledge of CLK_DIV.
- rdn, wrn and tbre/tsre polling are synchronous to clk. The host may run on the opposite clk edge; every strobe level must be held ≥1 full clk cycle.

## Test plan
- Reset with CLK_DIV=4 -> txd=1, tbre=1, tsre=1, data_ready=0, ram1_data high-Z.
- Write 0xA5 (wrn low 1 cycle) -> tbre pulses 0 for 1 cycle; txd carries 0,1,0,1,0,0,1,0,1,1 at 4 cycles per bit; tsre=0 for exactly 40 cycles.
- Write 0x3C, then write 0xC3 as soon as tbre=1 -> two back-to-back frames with no idle gap; tsre stays 0 for 80 cycles; a third write while tbre=0 is dropped.
- Drive rxd with a 0x5A frame -> data_ready=1; rdn low shows 0x5A on the bus; rdn rising clears data_ready.
- Send rxd frames 0x11 then 0x22 without reading -> buffer reads 0x22 (overrun). Send a frame with stop=0 -> data_ready unchanged. A 1-cycle rxd low glitch -> no byte received.
- Assert rst mid-TX and mid-RX frame -> txd=1 immediately, no byte is stored, and a following 0x81 exchange works.
